// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory access unit:
//   - access size encodings (f3[1:0])
//   - index of the unsigned-load bit in f3
//   - FSM state encodings (IDLE / REQ / DONE)
//   - bus width in bytes
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

   typedef logic [1:0] size_t;
   typedef logic [1:0] state_t;

   localparam size_t SIZE_BYTE = 2'b00;
   localparam size_t SIZE_HALF = 2'b01;
   localparam size_t SIZE_WORD = 2'b10;

   localparam int F3_UNSIGNED_BIT = 2;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_REQ  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam int BUS_BYTES = 4;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the memory access unit.
// Request side (live core request):
//   req_off     in   byte offset addr[1:0]
//   req_size    in   effective access size
//   wdata       in   right-aligned store data
//   be          out  byte enables
//   wdata_lanes out  store data replicated across the addressed lanes
//   misaligned  out  request is misaligned or of illegal size
// Response side (parameters latched when the bus cycle was issued):
//   rsp_off, rsp_size, rsp_unsigned  in  offset, size, zero-extend select
//   rdata_raw   in   raw bus read word
//   rdata_ext   out  shifted and sign/zero-extended load data
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  req_off,
   input  logic [1:0]  req_size,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lanes,
   output logic        misaligned,
   input  logic [1:0]  rsp_off,
   input  logic [1:0]  rsp_size,
   input  logic        rsp_unsigned,
   input  logic [31:0] rdata_raw,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      be          = '0;
      wdata_lanes = wdata;
      misaligned  = 1'b0;
      case (req_size)
         SIZE_BYTE: begin
            be          = 4'b0001 << req_off;
            wdata_lanes = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            be          = 4'b0011 << req_off;
            wdata_lanes = {2{wdata[15:0]}};
            misaligned  = req_off[0];
         end
         SIZE_WORD: begin
            be          = '1;
            misaligned  = |req_off;
         end
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      shifted   = rdata_raw >> {rsp_off, 3'b000};
      rdata_ext = shifted;
      case (rsp_size)
         SIZE_BYTE: rdata_ext = rsp_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: rdata_ext = rsp_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
         default:   rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Turns the control unit's level-held mem_read/mem_write requests into a
// single transaction on a word-wide, byte-enabled valid/ready bus, steers
// byte lanes, extends load data and returns a one-cycle mem_complete pulse.
// Misaligned or illegal-size requests are flagged and never reach the bus.
//
// Optional feature (define MEM_ACCESS_TIMEOUT_EN): a bus watchdog aborts a
// REQ that sees no bus_ready within TIMEOUT_CYCLES cycles and pulses
// access_fault. Without it access_fault is tied 0 and REQ waits forever.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read, mem_write   core requests (write wins if both high)
//   fetch                 instruction fetch: word, unsigned
//   f3                    [1:0] size, [2] unsigned
//   addr, wdata           byte address, right-aligned store data
//   rdata                 extended load data, held until next completion
//   mem_complete          one-cycle completion pulse
//   misaligned            combinational misalignment flag
//   access_fault          one-cycle bus timeout pulse
//   bus_addr/be/wdata     word address, byte enables, replicated store data
//   bus_read, bus_write   bus request valid
//   bus_ready, bus_rdata  bus handshake and read word (same cycle)
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  fetch,
   input  logic [2:0]            f3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  mem_complete,
   output logic                  misaligned,
   output logic                  access_fault,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [3:0]            bus_be,
   output logic [31:0]           bus_wdata,
   output logic                  bus_read,
   output logic                  bus_write,
   input  logic                  bus_ready,
   input  logic [31:0]           bus_rdata
);

   state_t      state;
   logic        req_any;
   size_t       req_size;
   logic        req_unsigned;
   logic [1:0]  lat_off;
   size_t       lat_size;
   logic        lat_unsigned;
   logic        dropped;
   logic        keep;
   logic        timeout_hit;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [31:0] rdata_ext;

   assign req_any      = mem_read | mem_write;
   assign req_size     = fetch ? SIZE_WORD : f3[1:0];
   assign req_unsigned = fetch | f3[F3_UNSIGNED_BIT];

   // A request withdrawn at any point during REQ (exception redirect) still
   // finishes its bus cycle but must not signal completion or update rdata.
   assign keep = ~dropped & req_any;

   mem_lane_align u_align (
      .req_off      (addr[1:0]),
      .req_size     (req_size),
      .wdata        (wdata),
      .be           (be_nxt),
      .wdata_lanes  (wdata_nxt),
      .misaligned   (misaligned),
      .rsp_off      (lat_off),
      .rsp_size     (lat_size),
      .rsp_unsigned (lat_unsigned),
      .rdata_raw    (bus_rdata),
      .rdata_ext    (rdata_ext)
   );

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt;

   assign timeout_hit = (state == ST_REQ) && !bus_ready &&
                        (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Held at zero outside REQ, so it starts from zero on every REQ entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt       <= '0;
         access_fault <= 1'b0;
      end else begin
         access_fault <= timeout_hit;
         if (state != ST_REQ)
            wd_cnt <= '0;
         else if (!bus_ready)
            wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
   assign access_fault   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         bus_read     <= 1'b0;
         bus_write    <= 1'b0;
         bus_addr     <= '0;
         bus_be       <= '0;
         bus_wdata    <= '0;
         rdata        <= '0;
         mem_complete <= 1'b0;
         lat_off      <= '0;
         lat_size     <= SIZE_WORD;
         lat_unsigned <= 1'b0;
         dropped      <= 1'b0;
      end else begin
         mem_complete <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_any && !misaligned) begin
                  bus_write    <= mem_write;
                  bus_read     <= ~mem_write;
                  bus_addr     <= {addr[ADDR_WIDTH-1:2], 2'b00};
                  bus_be       <= be_nxt;
                  bus_wdata    <= wdata_nxt;
                  lat_off      <= addr[1:0];
                  lat_size     <= req_size;
                  lat_unsigned <= req_unsigned;
                  dropped      <= 1'b0;
                  state        <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!req_any)
                  dropped <= 1'b1;
               if (bus_ready) begin
                  bus_read     <= 1'b0;
                  bus_write    <= 1'b0;
                  mem_complete <= keep;
                  if (keep && bus_read)
                     rdata <= rdata_ext;
                  state <= ST_DONE;
               end else if (timeout_hit) begin
                  bus_read  <= 1'b0;
                  bus_write <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int TO   = 4;
   localparam int MAXD = 3;
`else
   localparam int TO   = 255;
   localparam int MAXD = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, fetch;
   logic [2:0]  f3;
   logic [31:0] addr, wdata, rdata;
   logic        mem_complete, misaligned, access_fault;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_read, bus_write, bus_ready;
   logic [31:0] bus_rdata;

   mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .fetch(fetch), .f3(f3), .addr(addr), .wdata(wdata), .rdata(rdata),
      .mem_complete(mem_complete), .misaligned(misaligned),
      .access_fault(access_fault), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_read(bus_read), .bus_write(bus_write),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          wr;
   } bus_exp_t;

   typedef struct {
      int unsigned cyc;
      logic [31:0] rdata;
   } cmp_exp_t;

   bus_exp_t    bus_q[$];
   cmp_exp_t    cmp_q[$];
   int          nvec = 0;
   int          nerr = 0;
   int unsigned cyc = 0;
   logic [31:0] model_rdata = '0;
   bit          bus_act_q = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic event_fail(input string nm);
      nvec++;
      nerr++;
      $display("FAIL %s: event not expected/not seen (cycle %0d)", nm, cyc);
   endtask

   // ---------------- reference model ----------------
   function automatic int eff_size(input bit f, input logic [2:0] f3v);
      return f ? 2 : int'(f3v[1:0]);
   endfunction

   function automatic bit model_misal(input int sz, input logic [31:0] a);
      if (sz == 3) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
      logic [3:0]  b = '0;
      int unsigned off = a % 4;
      int unsigned n = 1 << sz;
      for (int unsigned i = 0; i < 4; i++)
         if (i >= off && i < off + n) b[i] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] w);
      logic [31:0] r;
      int unsigned n = 1 << sz;
      for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input int sz, input bit uns,
                                              input logic [31:0] a, input logic [31:0] word);
      longint v = longint'(word >> (8 * (a % 4)));
      if (sz == 0) begin
         v = v % 256;
         if (!uns && v >= 128) v = v - 256;
      end else if (sz == 1) begin
         v = v % 65536;
         if (!uns && v >= 32768) v = v - 65536;
      end
      return 32'(v);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   bus_exp_t mb;
   cmp_exp_t mc;

   always @(negedge clk) begin
      if (!rst_n) begin
         bus_act_q = 1'b0;
      end else begin
         if ((bus_read | bus_write) && !bus_act_q) begin
            if (bus_q.size() == 0) event_fail("bus_unexpected");
            else begin
               mb = bus_q.pop_front();
               chk("bus_addr", bus_addr, mb.addr);
               chk("bus_be", {28'h0, bus_be}, {28'h0, mb.be});
               chk("bus_dir", {30'h0, bus_write, bus_read}, {30'h0, mb.wr, !mb.wr});
               if (mb.wr) chk("bus_wdata", bus_wdata, mb.wdata);
            end
         end
         bus_act_q = bus_read | bus_write;
         if (mem_complete) begin
            if (cmp_q.size() == 0) event_fail("complete_unexpected");
            else begin
               mc = cmp_q.pop_front();
               chk("complete_cycle", cyc, mc.cyc);
               chk("rdata", rdata, mc.rdata);
               chk("access_fault_on_complete", {31'h0, access_fault}, 32'h0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic access(input bit rd, input bit wr, input bit f, input logic [2:0] f3v,
                         input logic [31:0] a, input logic [31:0] wd, input int d,
                         input logic [31:0] word, input bit drop, input string tag);
      int          sz = eff_size(f, f3v);
      bit          mis = model_misal(sz, a);
      bit          seen = 1'b0;
      bus_exp_t    be_e;
      cmp_exp_t    ce;
      int unsigned k;
      @(posedge clk); #1;
      k = cyc;
      mem_read = rd; mem_write = wr; fetch = f; f3 = f3v; addr = a; wdata = wd;
      if (!mis) begin
         be_e.addr  = a & ~32'd3;
         be_e.be    = model_be(sz, a);
         be_e.wdata = model_wdata(sz, wd);
         be_e.wr    = wr;
         bus_q.push_back(be_e);
         if (!drop) begin
            if (!wr) model_rdata = model_load(sz, f | f3v[2], a, word);
            ce.cyc   = k + 2 + d;
            ce.rdata = model_rdata;
            cmp_q.push_back(ce);
         end
      end
      #1 chk({tag, "_misaligned"}, {31'h0, misaligned}, {31'h0, mis});
      if (mis) begin
         repeat (4) @(negedge clk);
         mem_read = 1'b0; mem_write = 1'b0;
         return;
      end
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus_read | bus_write;
      end
      if (!seen) begin
         event_fail({tag, "_bus_start_timeout"});
         mem_read = 1'b0; mem_write = 1'b0;
         return;
      end
      if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
      for (int i = 0; i < d; i++) begin
         chk({tag, "_hold_dir"}, {30'h0, bus_write, bus_read}, {30'h0, wr, !wr});
         chk({tag, "_hold_addr"}, bus_addr, a & ~32'd3);
         @(negedge clk);
      end
      bus_ready = 1'b1; bus_rdata = word;
      @(posedge clk); #1;
      bus_ready = 1'b0; bus_rdata = $urandom;
      if (drop) begin
         repeat (3) @(posedge clk);
         #1 chk({tag, "_rdata_after_drop"}, rdata, model_rdata);
         return;
      end
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         seen = mem_complete;
         if (!seen) @(negedge clk);
      end
      if (!seen) event_fail({tag, "_complete_timeout"});
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_rdata_hold"}, rdata, model_rdata);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bit       rd, wr, f, drop;
      bit       seen;
      bus_exp_t be_e;
      rst_n = 1'b0; mem_read = 0; mem_write = 0; fetch = 0; f3 = '0;
      addr = '0; wdata = '0; bus_ready = 0; bus_rdata = '0;
      #3;
      chk("reset_bus_valid", {30'h0, bus_read, bus_write}, 32'h0);
      chk("reset_pulses", {30'h0, mem_complete, access_fault}, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_bus_addr", bus_addr, 32'h0);
      chk("reset_bus_be_wdata", bus_wdata | {28'h0, bus_be}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // directed cases
      access(1, 0, 1, 3'b011, 32'h100, 0, 0, 32'h00500093, 0, "fetch");
      repeat (3) @(posedge clk);
      #1 chk("fetch_rdata_later", rdata, 32'h00500093);
      access(1, 0, 0, 3'b000, 32'h203, 0, 1, 32'h80FF1234, 0, "lb");
      chk("lb_value", rdata, 32'hFFFFFF80);
      access(1, 0, 0, 3'b100, 32'h203, 0, 0, 32'h80FF1234, 0, "lbu");
      chk("lbu_value", rdata, 32'h00000080);
      access(0, 1, 0, 3'b001, 32'h302, 32'h0000BEEF, MAXD, 32'h0, 0, "sh");
      access(1, 0, 0, 3'b010, 32'h401, 0, 0, 32'h0, 0, "lw_mis");
      access(1, 0, 0, 3'b001, 32'h401, 0, 0, 32'h0, 0, "lh_mis");
      access(1, 1, 0, 3'b010, 32'h600, 32'h12345678, 1, 32'hDEADBEEF, 0, "both_write_wins");
      access(1, 0, 0, 3'b010, 32'h500, 0, 2, 32'hCAFEF00D, 1, "drop");

      // reset during REQ
      @(posedge clk); #1;
      mem_read = 1; fetch = 0; f3 = 3'b010; addr = 32'h700;
      be_e.addr = 32'h700; be_e.be = 4'hF; be_e.wdata = '0; be_e.wr = 0;
      bus_q.push_back(be_e);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus_read;
      end
      if (!seen) event_fail("rst_bus_start_timeout");
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_bus_drop", {30'h0, bus_read, bus_write}, 32'h0);
      model_rdata = '0;
      chk("rst_mid_rdata", rdata, 32'h0);
      @(posedge clk); #1;
      mem_read = 0; rst_n = 1'b1;
      access(1, 0, 0, 3'b101, 32'h802, 0, 0, 32'h9ABC1234, 0, "after_reset");

`ifdef MEM_ACCESS_TIMEOUT_EN
      @(posedge clk); #1;
      mem_read = 1; fetch = 0; f3 = 3'b010; addr = 32'h900;
      be_e.addr = 32'h900; be_e.be = 4'hF; be_e.wdata = '0; be_e.wr = 0;
      bus_q.push_back(be_e);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus_read;
      end
      if (!seen) event_fail("to_bus_start_timeout");
      repeat (TO - 1) begin
         @(negedge clk);
         chk("to_no_early_fault", {31'h0, access_fault}, 32'h0);
      end
      @(negedge clk);
      chk("to_fault_pulse", {31'h0, access_fault}, 32'h1);
      chk("to_bus_dropped", {31'h0, bus_read}, 32'h0);
      @(posedge clk); #1 mem_read = 0;
      @(negedge clk);
      chk("to_fault_single", {31'h0, access_fault}, 32'h0);
      chk("to_rdata_kept", rdata, model_rdata);
`endif

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         wr   = ($urandom_range(0, 2) == 0);
         rd   = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
         f    = !wr && ($urandom_range(0, 4) == 0);
         drop = ($urandom_range(0, 9) == 0);
         access(rd, wr, f, 3'($urandom), $urandom, $urandom, $urandom_range(0, MAXD),
                $urandom, drop, "rnd");
      end

      repeat (4) @(posedge clk);
      chk("bus_queue_drained", bus_q.size(), 0);
      chk("cmp_queue_drained", cmp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
